// File: rtl/rv32i_pkg.sv
// Shared RV32I types: FSM states, decoder class bit positions, writeback selects, opcodes.
package rv32i_pkg;

    localparam int unsigned CLASS_W = 10;
    localparam int unsigned WB_W    = 2;
    localparam int unsigned WAIT_W  = 16;

    // Bit positions inside the one-hot decoder class vector
    localparam int unsigned CLS_ALUREG = 0;
    localparam int unsigned CLS_ALUIMM = 1;
    localparam int unsigned CLS_BRANCH = 2;
    localparam int unsigned CLS_JALR   = 3;
    localparam int unsigned CLS_JAL    = 4;
    localparam int unsigned CLS_AUIPC  = 5;
    localparam int unsigned CLS_LUI    = 6;
    localparam int unsigned CLS_LOAD   = 7;
    localparam int unsigned CLS_STORE  = 8;
    localparam int unsigned CLS_SYSTEM = 9;

    // Writeback mux sources
    localparam logic [WB_W-1:0] WB_ALU  = 2'd0;
    localparam logic [WB_W-1:0] WB_LOAD = 2'd1;
    localparam logic [WB_W-1:0] WB_PC4  = 2'd2;
    localparam logic [WB_W-1:0] WB_UIMM = 2'd3;

    // Major opcodes, shared with the decoder
    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        WAIT_INSTR = 3'd1,
        EXECUTE    = 3'd2,
        WAIT_LOAD  = 3'd3,
        WAIT_STORE = 3'd4,
        HALT       = 3'd5,
        FAULT      = 3'd6
    } state_t;

    // True when exactly one class bit is set
    function automatic logic is_onehot(input logic [CLASS_W-1:0] v);
        return (v != '0) && ((v & (v - CLASS_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control FSM with retired-instruction counter and memory watchdog.
module rv32i_mc_control
    import rv32i_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [CLASS_W-1:0] instr_class,
    input  logic [2:0]         funct3,
    input  logic               mem_ready,
    output logic               mem_rstrb,
    output logic               mem_wr,
    output logic               addr_sel,
    output logic               ir_we,
    output logic               pc_we,
    output logic               rf_we,
    output logic [WB_W-1:0]    wb_sel,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   instret
);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               retire_c;
    logic               wait_limit_c;

    // Last permitted wait cycle: one more miss would exceed MAX_WAIT
    assign wait_limit_c = (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));

    // State, watchdog and retire counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instret_q  <= instret_d;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        retire_c   = 1'b0;
        mem_rstrb  = 1'b0;
        mem_wr     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;

        case (state_q)
            FETCH: begin
                mem_rstrb  = 1'b1;
                wait_cnt_d = '0;
                state_d    = WAIT_INSTR;
            end

            WAIT_INSTR: begin
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = EXECUTE;
                end else if (wait_limit_c) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            EXECUTE: begin
                if (!is_onehot(instr_class)) begin
                    state_d = FAULT;
                end else if (instr_class[CLS_ALUREG] || instr_class[CLS_ALUIMM]) begin
                    rf_we    = 1'b1;
                    wb_sel   = WB_ALU;
                    pc_we    = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (instr_class[CLS_JAL] || instr_class[CLS_JALR]) begin
                    rf_we    = 1'b1;
                    wb_sel   = WB_PC4;
                    pc_we    = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (instr_class[CLS_LUI] || instr_class[CLS_AUIPC]) begin
                    rf_we    = 1'b1;
                    wb_sel   = WB_UIMM;
                    pc_we    = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (instr_class[CLS_BRANCH]) begin
                    pc_we    = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (instr_class[CLS_LOAD]) begin
                    mem_rstrb  = 1'b1;
                    addr_sel   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = WAIT_LOAD;
                end else if (instr_class[CLS_STORE]) begin
                    mem_wr     = 1'b1;
                    addr_sel   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = WAIT_STORE;
                end else begin
                    // SYSTEM: ECALL/EBREAK stop the core, CSR ops retire as NOPs
                    retire_c = 1'b1;
                    if (funct3 == 3'd0) begin
                        state_d = HALT;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end

            WAIT_LOAD: begin
                addr_sel = 1'b1;
                if (mem_ready) begin
                    rf_we    = 1'b1;
                    wb_sel   = WB_LOAD;
                    pc_we    = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (wait_limit_c) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            WAIT_STORE: begin
                addr_sel = 1'b1;
                if (mem_ready) begin
                    pc_we    = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (wait_limit_c) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            HALT: begin
                state_d = HALT;
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = FAULT;
            end
        endcase

        // Strobes must be quiet while reset is held, even though the state reads FETCH
        if (!resetn) begin
            mem_rstrb = 1'b0;
            mem_wr    = 1'b0;
            addr_sel  = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            rf_we     = 1'b0;
            wb_sel    = WB_ALU;
            retire_c  = 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_comb begin
        instret_d = instret_q;
        if (retire_c) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    assign halted  = (state_q == HALT);
    assign fault   = (state_q == FAULT);
    assign instret = instret_q;

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Directed bench for rv32i_mc_control: vector table plus multi-cycle corner sequences.
module tb_rv32i_mc_control;
    import rv32i_pkg::*;

    localparam int unsigned CW = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic [9:0]     instr_class;
    logic [2:0]     funct3;
    logic           mem_ready;
    logic           mem_rstrb, mem_wr, addr_sel, ir_we, pc_we, rf_we;
    logic [1:0]     wb_sel;
    logic           halted, fault;
    logic [CW-1:0]  instret;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_instret;

    always #5 clk = ~clk;

    rv32i_mc_control #(.CNT_W(CW), .MAX_WAIT(4)) dut (
        .clk(clk), .resetn(resetn), .instr_class(instr_class), .funct3(funct3),
        .mem_ready(mem_ready), .mem_rstrb(mem_rstrb), .mem_wr(mem_wr),
        .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .wb_sel(wb_sel), .halted(halted), .fault(fault), .instret(instret)
    );

    typedef struct {
        string      name;
        logic [9:0] cls;
        logic [2:0] f3;
        logic [7:0] exec;
        logic [7:0] done;
        bit         mem;
    } vec_t;

    vec_t vecs[10];

    // {mem_rstrb, mem_wr, addr_sel, ir_we, pc_we, rf_we, wb_sel}
    function automatic logic [7:0] outs();
        return {mem_rstrb, mem_wr, addr_sel, ir_we, pc_we, rf_we, wb_sel};
    endfunction

    function automatic logic [9:0] cbit(input int unsigned idx);
        return 10'(1) << idx;
    endfunction

    function automatic vec_t mkv(input string n, input logic [9:0] c, input logic [2:0] f,
                                 input logic [7:0] e, input logic [7:0] d, input bit m);
        vec_t v;
        v.name = n; v.cls = c; v.f3 = f; v.exec = e; v.done = d; v.mem = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Hold reset two cycles, check the quiet state, release just after a rising edge
    task automatic do_reset();
        resetn = 1'b0; mem_ready = 1'b0; instr_class = '0; funct3 = '0;
        step(); step();
        smp();
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_halted", 32'(halted), 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        chk("reset_instret", 32'(instret), 32'h0);
        step();
        resetn = 1'b1;
        exp_instret = '0;
    endtask

    // FETCH then WAIT_INSTR with an immediate response; leaves the FSM entering EXECUTE
    task automatic fetch_decode(input string n, input logic [9:0] c, input logic [2:0] f);
        instr_class = c; funct3 = f; mem_ready = 1'b1;
        smp(); chk({n, "_fetch"}, 32'(outs()), 32'h80);
        step();
        smp(); chk({n, "_wait_instr"}, 32'(outs()), 32'h10);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;

        vecs[0] = mkv("alureg", cbit(CLS_ALUREG), 3'd0, 8'h0C, 8'h00, 1'b0);
        vecs[1] = mkv("aluimm", cbit(CLS_ALUIMM), 3'd0, 8'h0C, 8'h00, 1'b0);
        vecs[2] = mkv("branch", cbit(CLS_BRANCH), 3'd0, 8'h08, 8'h00, 1'b0);
        vecs[3] = mkv("jalr",   cbit(CLS_JALR),   3'd0, 8'h0E, 8'h00, 1'b0);
        vecs[4] = mkv("jal",    cbit(CLS_JAL),    3'd0, 8'h0E, 8'h00, 1'b0);
        vecs[5] = mkv("auipc",  cbit(CLS_AUIPC),  3'd0, 8'h0F, 8'h00, 1'b0);
        vecs[6] = mkv("lui",    cbit(CLS_LUI),    3'd0, 8'h0F, 8'h00, 1'b0);
        vecs[7] = mkv("load",   cbit(CLS_LOAD),   3'd0, 8'hA0, 8'h2D, 1'b1);
        vecs[8] = mkv("store",  cbit(CLS_STORE),  3'd0, 8'h60, 8'h28, 1'b1);
        vecs[9] = mkv("csrnop", cbit(CLS_SYSTEM), 3'd1, 8'h08, 8'h00, 1'b0);

        // Table: every class with zero-latency memory, two passes so the 4-bit counter wraps
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) begin
                fetch_decode(vecs[i].name, vecs[i].cls, vecs[i].f3);
                smp(); chk({vecs[i].name, "_exec"}, 32'(outs()), 32'(vecs[i].exec));
                if (vecs[i].mem) begin
                    step();
                    smp(); chk({vecs[i].name, "_done"}, 32'(outs()), 32'(vecs[i].done));
                end
                step();
                exp_instret = exp_instret + CW'(1);
                chk({vecs[i].name, "_instret"}, 32'(instret), 32'(exp_instret));
            end
        end

        // Load with three missed cycles; ready on the last permitted wait cycle
        do_reset();
        fetch_decode("ld_slow", cbit(CLS_LOAD), 3'd0);
        smp(); chk("ld_slow_exec", 32'(outs()), 32'hA0);
        mem_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            smp(); chk("ld_slow_wait", 32'(outs()), 32'h20);
            step();
        end
        mem_ready = 1'b1;
        smp(); chk("ld_slow_done", 32'(outs()), 32'h2D);
        step();
        chk("ld_slow_instret", 32'(instret), 32'h1);
        chk("ld_slow_nofault", 32'(fault), 32'h0);
        smp(); chk("ld_slow_refetch", 32'(outs()), 32'h80);
        step();

        // Load timeout: four missed wait cycles fault
        do_reset();
        fetch_decode("ld_to", cbit(CLS_LOAD), 3'd0);
        mem_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            smp(); chk("ld_to_wait", 32'(outs()), 32'h20);
            step();
        end
        chk("ld_to_fault", 32'(fault), 32'h1);
        chk("ld_to_outs", 32'(outs()), 32'h0);
        chk("ld_to_instret", 32'(instret), 32'h0);
        mem_ready = 1'b1;
        step(); step();
        chk("ld_to_sticky", 32'(fault), 32'h1);

        // Store timeout uses the same watchdog
        do_reset();
        fetch_decode("st_to", cbit(CLS_STORE), 3'd0);
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("st_to_fault", 32'(fault), 32'h1);

        // ECALL/EBREAK: retire once, then stay halted with no fetches
        do_reset();
        fetch_decode("halt", cbit(CLS_SYSTEM), 3'd0);
        smp(); chk("halt_exec", 32'(outs()), 32'h0);
        step();
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_instret", 32'(instret), 32'h1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (outs() != 8'h0 || !halted) seen = 1'b1;
            step();
        end
        chk("halt_quiet", 32'(seen), 32'h0);
        chk("halt_instret_hold", 32'(instret), 32'h1);

        // Illegal opcode (all-zero class)
        do_reset();
        fetch_decode("illegal", 10'h000, 3'd0);
        smp(); chk("illegal_exec", 32'(outs()), 32'h0);
        step();
        chk("illegal_fault", 32'(fault), 32'h1);
        chk("illegal_halted", 32'(halted), 32'h0);
        chk("illegal_instret", 32'(instret), 32'h0);

        // Class with two bits set is also illegal
        do_reset();
        fetch_decode("multi", 10'h003, 3'd0);
        smp(); chk("multi_exec", 32'(outs()), 32'h0);
        step();
        chk("multi_fault", 32'(fault), 32'h1);

        // Async reset mid load wait, then a stale ready during the first FETCH
        do_reset();
        fetch_decode("rst_alu", cbit(CLS_ALUREG), 3'd0);
        step();
        chk("rst_alu_instret", 32'(instret), 32'h1);
        fetch_decode("rst_ld", cbit(CLS_LOAD), 3'd0);
        mem_ready = 1'b0;
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_outs", 32'(outs()), 32'h0);
        chk("rst_async_instret", 32'(instret), 32'h0);
        mem_ready = 1'b1;
        instr_class = cbit(CLS_ALUREG);
        step(); step();
        resetn = 1'b1;
        smp(); chk("rst_fetch", 32'(outs()), 32'h80);
        step();
        smp(); chk("rst_wait_instr", 32'(outs()), 32'h10);
        step();
        smp(); chk("rst_exec", 32'(outs()), 32'h0C);
        step();
        chk("rst_instret", 32'(instret), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
